// File: rtl/pipe_carry_sel_adder_pkg.sv
// rtl/pipe_carry_sel_adder_pkg.sv - shared defaults, stage-count helper and stage payload layout
//
// Package pipe_adder_pkg:
//   DEF_WIDTH / DEF_BLK / DEF_BPS : default operand width, block width, blocks per stage
//   calc_nstg()                   : number of pipeline stages (= latency in cycles)
//   stage_def_t                   : stage register payload at the default width
package pipe_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK   = 4;
    localparam int DEF_BPS   = 2;

    function automatic int calc_nstg(input int width, input int blk, input int bps);
        return width / (blk * bps);
    endfunction

    // Field order shared with the width-parameterised stage_t in the top module.
    // carry is the carry leaving the stage; sub keeps the operation so later
    // stages can form their own slice of the effective B operand.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 sub;
        logic                 ovf;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_WIDTH-1:0] sum;
    } stage_def_t;

endpackage

// File: rtl/pipe_carry_sel_adder_if.sv
// rtl/pipe_carry_sel_adder_if.sv - operand/result stream interface of the pipelined adder
//
// Operand stream (source -> adder): i_valid, i_a, i_b, i_c_in, i_sub ; o_ready back
// Result stream  (adder -> sink)  : o_valid, o_sum, o_c_out, o_ovf   ; i_ready back
// slave modport is the adder side, master modport is the source/sink side.
interface pipe_carry_sel_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c_in;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_c_out;
    logic             o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_c_in, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_c_out, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_c_in, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_c_out, o_ovf
    );
endinterface

// File: rtl/pipe_carry_sel_adder_csel_block.sv
// rtl/pipe_carry_sel_adder_csel_block.sv - BLK-bit dual ripple adder with carry-select mux
//
// Ports:
//   a, b   : BLK-bit operand slices (b already inverted for subtract)
//   c_sel  : incoming block carry, selects which precomputed result is used
//   sum    : BLK-bit selected sum
//   c_out  : selected carry out of the block
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           c_sel,
    output logic [BLK-1:0] sum,
    output logic           c_out
);
    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic [BLK:0]   r0;
    logic [BLK:0]   r1;

    // Both ripple chains run in parallel with the upstream carry, so the
    // block only adds one mux delay once c_sel settles.
    always_comb begin
        s0    = '0;
        s1    = '0;
        r0    = '0;
        r1    = '0;
        r0[0] = 1'b0;
        r1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ r0[i];
            r0[i+1] = (a[i] & b[i]) | (r0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ r1[i];
            r1[i+1] = (a[i] & b[i]) | (r1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum   = c_sel ? s1 : s0;
    assign c_out = c_sel ? r1[BLK] : r0[BLK];

endmodule

// File: rtl/pipe_carry_sel_adder.sv
// rtl/pipe_carry_sel_adder.sv - pipelined carry-select adder/subtractor with valid/ready streams
//
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset, discards every in-flight beat
//   bus : pipe_carry_sel_adder_if.slave (operand stream in, result stream out)
// Each of the NSTG stages resolves BPS blocks of BLK bits; the carry and the
// untouched upper operand bits ride in the stage register (skewed pipeline).
module pipe_carry_sel_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK,
    parameter int BPS   = DEF_BPS
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_carry_sel_adder_if.slave  bus
);
    localparam int SW   = BLK * BPS;
    localparam int NSTG = calc_nstg(WIDTH, BLK, BPS);

    if ((WIDTH % SW) != 0 || NSTG < 1) begin : g_bad_cfg
        $error("pipe_carry_sel_adder: WIDTH must be a non-zero multiple of BLK*BPS");
    end

    // Same layout as pipe_adder_pkg::stage_def_t, sized for this instance.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             sub;
        logic             ovf;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    stage_t          st_q [NSTG];
    logic [NSTG:0]   adv;

    // A stage may load when it is empty or its content moves on this cycle,
    // which collapses bubbles and lets a full pipe accept and emit together.
    always_comb begin
        adv       = '0;
        adv[NSTG] = bus.i_ready;
        for (int s = NSTG - 1; s >= 0; s--) begin
            adv[s] = ~st_q[s].valid | adv[s+1];
        end
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        stage_t          in_s;
        stage_t          nxt_s;
        logic [SW-1:0]   ssum;

        if (s == 0) begin : g_in0
            // Borrow-in is inverted so subtract becomes A + ~B + ~c_in.
            always_comb begin
                in_s       = '0;
                in_s.valid = bus.i_valid;
                in_s.sub   = bus.i_sub;
                in_s.carry = bus.i_c_in ^ bus.i_sub;
                in_s.a     = bus.i_a;
                in_s.b     = bus.i_b;
            end
        end else begin : g_inn
            assign in_s = st_q[s-1];
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            localparam int LO = (s * BPS + j) * BLK;
            logic           c_i;
            logic           c_o;
            logic [BLK-1:0] b_eff;

            if (j == 0) begin : g_cfirst
                assign c_i = in_s.carry;
            end else begin : g_cnext
                assign c_i = g_blk[j-1].c_o;
            end

            assign b_eff = in_s.b[LO +: BLK] ^ {BLK{in_s.sub}};

            csel_block #(.BLK(BLK)) u_blk (
                .a     (in_s.a[LO +: BLK]),
                .b     (b_eff),
                .c_sel (c_i),
                .sum   (ssum[j*BLK +: BLK]),
                .c_out (c_o)
            );
        end

        always_comb begin
            nxt_s                   = in_s;
            nxt_s.sum[s*SW +: SW]   = ssum;
            nxt_s.carry             = g_blk[BPS-1].c_o;
            nxt_s.ovf               = 1'b0;
            if (s == NSTG - 1) begin
                // Carry into the MSB is recovered from the MSB sum bit and its operands.
                nxt_s.ovf = in_s.a[WIDTH-1] ^ in_s.b[WIDTH-1] ^ in_s.sub
                          ^ ssum[SW-1] ^ g_blk[BPS-1].c_o;
            end
        end

        // Payload only changes with a real beat, so a bubble leaves the
        // previous result bits in place rather than loading junk.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q[s] <= '0;
            end else if (adv[s]) begin
                st_q[s].valid <= in_s.valid;
                if (in_s.valid) begin
                    st_q[s] <= nxt_s;
                end
            end
        end
    end

    assign bus.o_ready = adv[0];
    assign bus.o_valid = st_q[NSTG-1].valid;
    assign bus.o_sum   = st_q[NSTG-1].sum;
    assign bus.o_c_out = st_q[NSTG-1].carry;
    assign bus.o_ovf   = st_q[NSTG-1].ovf;

endmodule

// File: tb/tb_pipe_carry_sel_adder.sv
// tb/tb_pipe_carry_sel_adder.sv - self-checking bench for pipe_carry_sel_adder
module tb_pipe_carry_sel_adder;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_carry_sel_adder_if #(.WIDTH(W)) bus ();

    pipe_carry_sel_adder #(.WIDTH(W), .BLK(4), .BPS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic [33:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out   = '0;
    logic [33:0] out_bits;

    assign out_bits = {bus.o_ovf, bus.o_c_out, bus.o_sum};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ovf, c_out, sum}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] r;
        logic        ovf;
        be  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, be} + {32'b0, cin ^ sub};
        ovf = (a[31] == be[31]) && (r[31] != a[31]);
        return {ovf, r[32], r[31:0]};
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_stable", 64'({bus.o_valid, out_bits}), 64'({1'b1, prev_out}));
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(bus.o_valid), 64'(0));
                end else begin
                    check("sb_result", 64'(out_bits), 64'(exp_q.pop_front()));
                    n_out++;
                end
            end
            if (bus.i_valid && bus.o_ready)
                exp_q.push_back(model(bus.i_a, bus.i_b, bus.i_c_in, bus.i_sub));
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_out   = out_bits;
        end
    end

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [33:0] exp);
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.i_a = a; bus.i_b = b; bus.i_c_in = cin; bus.i_sub = sub;
        bus.i_valid = 1'b1; bus.i_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 64'(bus.o_ready), 64'(1));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check({tag, "_lat"}, 64'(seen ? lat : 0), 64'(4));
        if (seen) check(tag, 64'(out_bits), 64'(exp));
    endtask

    task automatic stream(input int n, input int vpct, input int rpct, input int max_cyc,
                          input bit chk_ready, output int cyc);
        int          sent;
        bit          have;
        logic [31:0] a, b;
        logic        c, s;
        sent = 0; cyc = 0; have = 1'b0;
        a = '0; b = '0; c = 1'b0; s = 1'b0;
        while (sent < n && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (!have && int'($urandom_range(99)) < vpct) begin
                a = $urandom; b = $urandom;
                c = 1'($urandom_range(1)); s = 1'($urandom_range(1));
                have = 1'b1;
            end
            bus.i_valid = have; bus.i_a = a; bus.i_b = b; bus.i_c_in = c; bus.i_sub = s;
            bus.i_ready = (int'($urandom_range(99)) < rpct);
            @(negedge clk);
            if (chk_ready) check("b2b_ready", 64'(bus.o_ready), 64'(1));
            if (have && bus.o_ready) begin
                have = 1'b0;
                sent++;
            end
        end
        check("stream_sent", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        while (exp_q.size() != 0 && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int cyc, n0, acc;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        bus.i_a = '0; bus.i_b = '0; bus.i_c_in = 1'b0; bus.i_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_out",   64'(out_bits),    64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus.o_ready), 64'(1));

        directed("add_all_ones", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        directed("add_pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        directed("sub_5_7",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        directed("add_cin",      32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, {1'b0, 1'b0, 32'h9999_999A});
        directed("sub_neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        directed("sub_borrow",   32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});
        directed("add_min_min",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
        directed("add_cin_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});

        // Back-to-back, no backpressure: one beat accepted every cycle.
        drain();
        n0 = n_out;
        stream(100, 100, 100, 200, 1'b1, cyc);
        check("b2b_cycles", 64'(cyc), 64'(100));
        drain();
        check("b2b_count", 64'(n_out - n0), 64'(100));

        // Full stall: pipeline absorbs exactly NSTG beats.
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b1; bus.i_ready = 1'b0;
            bus.i_a = 32'h1000_0000 * (acc + 1); bus.i_b = 32'h0000_0F0F + acc;
            bus.i_c_in = 1'(acc); bus.i_sub = 1'(acc >> 1);
            @(negedge clk);
            if (bus.o_ready) acc++;
        end
        check("stall_accepted", 64'(acc), 64'(4));
        check("stall_ready",    64'(bus.o_ready), 64'(0));
        n0 = n_out;
        drain();
        check("stall_drained", 64'(n_out - n0), 64'(4));

        // Random valid/ready toggling.
        stream(10000, 70, 70, 60000, 1'b0, cyc);
        drain();

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b1; bus.i_ready = 1'b1;
            bus.i_a = $urandom; bus.i_b = $urandom; bus.i_c_in = 1'b1; bus.i_sub = 1'(k);
        end
        @(posedge clk); #1;
        rst = 1'b1; bus.i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(bus.o_valid), 64'(0));
        check("midrst_out",   64'(out_bits),    64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(bus.o_valid), 64'(0));
        end
        directed("post_rst", 32'h0000_000F, 32'h0000_00F1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0100});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
